// File: rtl/cp_inserter.sv
`default_nettype none
// ============================================================================
// Module      : cp_inserter (with package data_type)
// Description : OFDM cyclic-prefix inserter. Symbols of N_FFT complex samples
//               are written into a ping-pong buffer. Each full bank is read
//               out as its last CP_LEN samples followed by the whole body.
//               Optional 16-bit symbol counter: CP_INSERTER_SYM_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

package data_type;
  localparam int R_W = 16;
  typedef logic signed [R_W-1:0] r_t;
endpackage

module cp_inserter
  import data_type::*;
#(
  parameter int N_FFT  = 64,
  parameter int CP_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  r_t   in_real,
  input  r_t   in_imag,
  output logic out_valid,
  input  logic out_ready,
  output r_t   out_real,
  output r_t   out_imag,
  output logic out_sop,
  output logic out_cp,
  output logic out_eop
`ifdef CP_INSERTER_SYM_CNT_EN
  ,
  output logic [15:0] sym_cnt
`endif
);

  localparam int                 c_idx_w   = $clog2(N_FFT);
  localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(N_FFT - 1);
  localparam logic [c_idx_w-1:0] c_cp_base = c_idx_w'(N_FFT - CP_LEN);
  localparam logic [c_idx_w-1:0] c_cp_last = c_idx_w'(CP_LEN - 1);
  localparam logic [c_idx_w-1:0] c_one     = c_idx_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  // Ping-pong sample storage; contents are never reset.
  r_t r_mem_re [2][N_FFT];
  r_t r_mem_im [2][N_FFT];

  logic [1:0]         r_full;
  logic               r_wr_sel;
  logic [c_idx_w-1:0] r_wr_idx;
  logic               w_wr_fire;
  logic               w_wr_last;

  state_t             r_state, w_state_nxt;
  logic               r_rd_sel, w_rd_sel_nxt;
  logic [c_idx_w-1:0] r_rd_idx, w_rd_idx_nxt;
  logic               w_load;
  logic               w_emit;
  logic               w_rd_done;
  logic [c_idx_w-1:0] w_addr;
  logic               w_sop, w_cp, w_eop;

  // A bank being drained is never written, so readiness only needs its flag.
  assign in_ready  = !r_full[r_wr_sel];
  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_last = (r_wr_idx == c_last);

  // The output register may take a new sample when empty or being drained.
  assign w_load = !out_valid || out_ready;

  // Write accepted samples into the current write bank.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem_re[r_wr_sel][r_wr_idx] <= in_real;
      r_mem_im[r_wr_sel][r_wr_idx] <= in_imag;
    end
  end

  // Writer position: advance per sample, flip banks after the last body sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel <= 1'b0;
      r_wr_idx <= '0;
    end else if (w_wr_fire) begin
      if (w_wr_last) begin
        r_wr_sel <= ~r_wr_sel;
        r_wr_idx <= '0;
      end else begin
        r_wr_idx <= r_wr_idx + c_one;
      end
    end
  end

  // Full flags: writer sets its bank, reader clears its bank; always different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      if (w_rd_done) r_full[r_rd_sel] <= 1'b0;
      if (w_wr_fire && w_wr_last) r_full[r_wr_sel] <= 1'b1;
    end
  end

  // Reader state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rd_sel <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_sel <= w_rd_sel_nxt;
      r_rd_idx <= w_rd_idx_nxt;
    end
  end

  // Reader next state and sample selection. IDLE emits CP sample 0 directly
  // when a bank is ready so the first output follows the filling edge at once.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_sel_nxt = r_rd_sel;
    w_rd_idx_nxt = r_rd_idx;
    w_emit       = 1'b0;
    w_rd_done    = 1'b0;
    w_addr       = '0;
    w_sop        = 1'b0;
    w_cp         = 1'b0;
    w_eop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_sel] && w_load) begin
          w_emit = 1'b1;
          w_addr = c_cp_base;
          w_sop  = 1'b1;
          w_cp   = 1'b1;
          if (CP_LEN == 1) begin
            w_state_nxt  = ST_BODY;
            w_rd_idx_nxt = '0;
          end else begin
            w_state_nxt  = ST_CP;
            w_rd_idx_nxt = c_one;
          end
        end
      end
      ST_CP: begin
        if (w_load) begin
          w_emit = 1'b1;
          w_addr = c_cp_base + r_rd_idx;
          w_sop  = (r_rd_idx == '0);
          w_cp   = 1'b1;
          if (r_rd_idx == c_cp_last) begin
            w_state_nxt  = ST_BODY;
            w_rd_idx_nxt = '0;
          end else begin
            w_rd_idx_nxt = r_rd_idx + c_one;
          end
        end
      end
      ST_BODY: begin
        if (w_load) begin
          w_emit = 1'b1;
          w_addr = r_rd_idx;
          w_eop  = (r_rd_idx == c_last);
          if (r_rd_idx == c_last) begin
            w_rd_done    = 1'b1;
            w_rd_sel_nxt = ~r_rd_sel;
            w_rd_idx_nxt = '0;
            w_state_nxt  = r_full[~r_rd_sel] ? ST_CP : ST_IDLE;
          end else begin
            w_rd_idx_nxt = r_rd_idx + c_one;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output register: holds data and flags while stalled downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sop   <= 1'b0;
      out_cp    <= 1'b0;
      out_eop   <= 1'b0;
    end else if (w_load) begin
      out_valid <= w_emit;
      out_sop   <= w_sop;
      out_cp    <= w_cp;
      out_eop   <= w_eop;
      if (w_emit) begin
        out_real <= r_mem_re[r_rd_sel][w_addr];
        out_imag <= r_mem_im[r_rd_sel][w_addr];
      end
    end
  end

`ifdef CP_INSERTER_SYM_CNT_EN
  // Count completed symbols on the output side, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt <= '0;
    end else if (out_valid && out_ready && out_eop) begin
      sym_cnt <= sym_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp_inserter
// Description : Directed self-checking bench for cp_inserter (N_FFT=64,
//               CP_LEN=16) with a symbol-level expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp_inserter;
  import data_type::*;

  localparam int N  = 64;
  localparam int CP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  r_t   in_real = '0;
  r_t   in_imag = '0;
  logic in_ready, out_valid, out_sop, out_cp, out_eop;
  r_t   out_real, out_imag;
`ifdef CP_INSERTER_SYM_CNT_EN
  logic [15:0] sym_cnt;
`endif

  cp_inserter #(.N_FFT(N), .CP_LEN(CP)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_sop  (out_sop),
    .out_cp   (out_cp),
    .out_eop  (out_eop)
`ifdef CP_INSERTER_SYM_CNT_EN
    ,
    .sym_cnt  (sym_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    bit sop;
    bit cp;
    bit eop;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sym_buf[N];
  int          checks = 0;
  int          errors = 0;
  int          in_base = 0;
  int          in_cnt = 0;
  int          widx = 0;
  int          nout = 0;
  int          eop_cnt = 0;
  int          gaps = 0;
  bit          started = 0;
  bit          stall_v = 0;
  logic [63:0] stall_snap = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (out #%0d)", tag, obs, exp, nout);
    end
  endtask

  function automatic logic [63:0] pack(input logic [15:0] re, input logic [15:0] im,
                                       input logic s, input logic c, input logic e);
    return {re, im, 29'b0, s, c, e};
  endfunction

  // A full symbol was accepted: queue CP (last CP samples) then the body.
  task automatic push_symbol();
    exp_t e;
    for (int c = 0; c < CP; c++) begin
      e.re = sym_buf[N-CP+c];
      e.im = -sym_buf[N-CP+c];
      e.sop = (c == 0);
      e.cp = 1'b1;
      e.eop = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < N; k++) begin
      e.re = sym_buf[k];
      e.im = -sym_buf[k];
      e.sop = 1'b0;
      e.cp = 1'b0;
      e.eop = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive inputs, score the transfers the next edge will make.
  task automatic cycle(input bit iv, input bit ordy);
    exp_t e;
    logic [15:0] v;
    v = 16'(in_base + in_cnt);
    in_valid = iv;
    in_real = v;
    in_imag = -v;
    out_ready = ordy;
    #1;
    if (!rst) begin
      if (stall_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", pack(out_real, out_imag, out_sop, out_cp, out_eop), stall_snap);
      end
      if (out_valid) started = 1;
      else if (started && exp_q.size() > 0) gaps++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample", pack(out_real, out_imag, out_sop, out_cp, out_eop),
                pack(e.re, e.im, e.sop, e.cp, e.eop));
          nout++;
          if (e.eop) eop_cnt++;
        end
      end
      stall_v = out_valid && !out_ready;
      stall_snap = pack(out_real, out_imag, out_sop, out_cp, out_eop);
      if (in_valid && in_ready) begin
        sym_buf[widx] = v;
        widx++;
        in_cnt++;
        if (widx == N) begin
          push_symbol();
          widx = 0;
        end
      end
    end else begin
      stall_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input int base);
    in_base = base;
    in_cnt = 0;
    nout = 0;
    gaps = 0;
    started = 0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    widx = 0;
    in_cnt = 0;
    stall_v = 0;
    eop_cnt = 0;
  endtask

  task automatic drain(input bit toggle);
    for (int t = 0; t < 3000 && exp_q.size() > 0; t++) cycle(0, toggle ? t[0] : 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cycle(0, 0);
    cycle(0, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", {out_real, out_imag}, 32'h0);
    check("rst_flags", {out_sop, out_cp, out_eop}, 3'b000);
    rst = 1'b0;
    clear_model();
    check("rst_in_ready", in_ready, 1);

    // Single symbol, real=k imag=-k, latency and first CP sample
    start_test(0);
    for (int t = 0; t < 200 && in_cnt < N; t++) cycle(1, 1);
    check("t1_fed", in_cnt, N);
    check("t1_lat_pre", out_valid, 0);
    cycle(0, 1);
    check("t1_lat_valid", out_valid, 1);
    check("t1_first_re", out_real, r_t'(48));
    check("t1_first_im", out_imag, r_t'(-48));
    check("t1_first_flags", {out_sop, out_cp, out_eop}, 3'b110);
    drain(0);
    check("t1_count", nout, 80);
    check("t1_idle", out_valid, 0);

    // Back-to-back: three symbols, continuous input, no output gap
    start_test(1000);
    for (int t = 0; t < 1000 && in_cnt < 3 * N; t++) cycle(1, 1);
    check("t2_fed", in_cnt, 3 * N);
    drain(0);
    check("t2_count", nout, 240);
    check("t2_gaps", gaps, 0);
`ifdef CP_INSERTER_SYM_CNT_EN
    check("t2_sym_cnt", sym_cnt, 16'(eop_cnt));
    check("t2_sym_cnt_abs", sym_cnt, 16'd4);
`endif

    // Backpressure: out_ready toggling, negative sample values
    start_test(-500);
    for (int t = 0; t < 1000 && in_cnt < 2 * N; t++) cycle(1, t[0]);
    check("t3_fed", in_cnt, 2 * N);
    drain(1);
    check("t3_count", nout, 160);

    // Full stall: both banks fill, a single pulse frees nothing
    start_test(2000);
    for (int t = 0; t < 600 && in_cnt < 2 * N; t++) cycle(1, 0);
    check("t4_fed", in_cnt, 2 * N);
    check("t4_in_ready", in_ready, 0);
    check("t4_valid", out_valid, 1);
    check("t4_head", out_real, r_t'(2048));
    cycle(1, 1);
    for (int t = 0; t < 4; t++) cycle(1, 0);
    check("t4_pulse_in_ready", in_ready, 0);
    check("t4_pulse_in_cnt", in_cnt, 2 * N);
    check("t4_pulse_nout", nout, 1);
    for (int t = 0; t < 300 && !in_ready; t++) cycle(0, 1);
    check("t4_free_at", nout, 79);
    drain(0);
    check("t4_count", nout, 160);

    // Reset mid-operation, then a fresh symbol
    start_test(3000);
    for (int t = 0; t < 300 && in_cnt < N + 30; t++) cycle(1, 1);
    check("t5_busy", out_valid, 1);
    rst = 1'b1;
    cycle(0, 1);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", {out_real, out_imag}, 32'h0);
    check("t5_rst_flags", {out_sop, out_cp, out_eop}, 3'b000);
    rst = 1'b0;
    clear_model();
    check("t5_in_ready", in_ready, 1);
    start_test(4000);
    for (int t = 0; t < 200 && in_cnt < N; t++) cycle(1, 1);
    for (int t = 0; t < 10 && !out_valid; t++) cycle(0, 1);
    check("t5_first_re", out_real, r_t'(4048));
    drain(0);
    check("t5_count", nout, 80);
`ifdef CP_INSERTER_SYM_CNT_EN
    check("t5_sym_cnt", sym_cnt, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
